// File: rtl/demux_1to2_8bit_stream.sv
// Buffered 1:2 demultiplexer for 8-bit valid/ready streams.
// Each output port owns a 2-entry FIFO and a modulo-256 handshake counter.
module demux_1to2_8bit_stream (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_sel,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out0_data,
  output logic       out0_valid,
  input  logic       out0_ready,
  output logic [7:0] out1_data,
  output logic       out1_valid,
  input  logic       out1_ready,
  output logic [1:0] count0,
  output logic [1:0] count1,
  output logic [7:0] xfer0,
  output logic [7:0] xfer1
);

  localparam int unsigned Depth = 2;
  localparam int unsigned NumPorts = 2;

  logic [7:0] mem_q    [NumPorts][Depth];
  logic [7:0] mem_d    [NumPorts][Depth];
  logic [1:0] count_q  [NumPorts];
  logic [1:0] count_d  [NumPorts];
  logic [7:0] xfer_q   [NumPorts];
  logic [7:0] xfer_d   [NumPorts];
  logic       rd_ptr_q [NumPorts];
  logic       rd_ptr_d [NumPorts];
  logic       wr_ptr_q [NumPorts];
  logic       wr_ptr_d [NumPorts];

  logic [NumPorts-1:0] out_ready;
  logic [NumPorts-1:0] push;
  logic [NumPorts-1:0] pop;

  assign out_ready = {out1_ready, out0_ready};

  // Strict in-order: only the selected port's occupancy gates acceptance.
  assign in_ready = in_sel ? (count_q[1] != 2'd2) : (count_q[0] != 2'd2);

  always_comb begin
    mem_d    = mem_q;
    count_d  = count_q;
    xfer_d   = xfer_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    push     = '0;
    pop      = '0;
    for (int p = 0; p < NumPorts; p++) begin
      push[p] = in_valid && in_ready && (in_sel == 1'(p));
      pop[p]  = (count_q[p] != 2'd0) && out_ready[p];
      if (push[p]) begin
        mem_d[p][wr_ptr_q[p]] = in_data;
        wr_ptr_d[p]           = ~wr_ptr_q[p];
      end
      if (pop[p]) begin
        rd_ptr_d[p] = ~rd_ptr_q[p];
        xfer_d[p]   = xfer_q[p] + 8'd1;
      end
      unique case ({push[p], pop[p]})
        2'b10:   count_d[p] = count_q[p] + 2'd1;
        2'b01:   count_d[p] = count_q[p] - 2'd1;
        default: count_d[p] = count_q[p];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NumPorts; p++) begin
        for (int e = 0; e < Depth; e++) begin
          mem_q[p][e] <= 8'h00;
        end
        count_q[p]  <= 2'd0;
        xfer_q[p]   <= 8'd0;
        rd_ptr_q[p] <= 1'b0;
        wr_ptr_q[p] <= 1'b0;
      end
    end else begin
      mem_q    <= mem_d;
      count_q  <= count_d;
      xfer_q   <= xfer_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  assign out0_data  = mem_q[0][rd_ptr_q[0]];
  assign out1_data  = mem_q[1][rd_ptr_q[1]];
  assign out0_valid = (count_q[0] != 2'd0);
  assign out1_valid = (count_q[1] != 2'd0);
  assign count0     = count_q[0];
  assign count1     = count_q[1];
  assign xfer0      = xfer_q[0];
  assign xfer1      = xfer_q[1];

endmodule

// File: doc/demux_1to2_8bit_stream.md
# demux_1to2_8bit_stream

Buffered 1:2 demultiplexer for 8-bit valid/ready streams, the routing counterpart of the 2:1 8-bit select mux. Each accepted input byte goes to output 0 or output 1 according to `in_sel` sampled with the byte. Each output has its own 2-entry FIFO, so a stalled consumer on one port does not lose data. Per-port transfer counters support debug and bench checking.

## Interface
- `DEPTH` = 2: entries per output FIFO; fixed at 2, not a tunable.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_data`  in  8  input byte.
- `in_sel`  in  1  destination: 0 routes to port 0, 1 routes to port 1.
- `in_valid`  in  1  `in_data`/`in_sel` are valid.
- `in_ready`  out  1  demux accepts this cycle.
- `out0_data`  out  8  port 0 head byte.
- `out0_valid`  out  1  port 0 FIFO non-empty.
- `out0_ready`  in  1  port 0 consumer accepts.
- `out1_data`  out  8  port 1 head byte.
- `out1_valid`  out  1  port 1 FIFO non-empty.
- `out1_ready`  in  1  port 1 consumer accepts.
- `count0`  out  2  port 0 occupancy, 0..2.
- `count1`  out  2  port 1 occupancy, 0..2.
- `xfer0`  out  8  port 0 completed output handshakes, modulo 256.
- `xfer1`  out  8  port 1 completed output handshakes, modulo 256.

## Operation
- Input handshake: a byte is accepted when `in_valid && in_ready` at a rising edge. The source holds `in_data`/`in_sel` stable while `in_valid && !in_ready`.
- `in_ready` = (`in_sel` ? `count1` != 2 : `count0` != 2).
  - Combinational from `in_sel` and registered occupancy only; never from `outN_ready`.
  - Independent of `in_valid`.
- Strict in-order input: if the selected port is full, input stalls even when the other port has room. There is no reordering or bypass.
- Each FIFO has a 1-bit read pointer, a 1-bit write pointer and a 2-bit count. Pointers wrap 1 to 0.
- `outN_valid` = (`countN` != 0). `outN_data` = entry at the read pointer.
- Output handshake: `outN_valid && outN_ready` at an edge pops the head and increments `xferN` (255 wraps to 0).
- `outN_data` is don't-care while `outN_valid`=0, but must not be X after reset.
- Simultaneous push and pop on the same port:
  - count 1: count stays 1; the old head leaves, the new byte becomes head.
  - count 2: push impossible (`in_ready`=0); pop proceeds, count becomes 2→1.
  - count 0: push only; pop impossible.
- Push to one port while popping the other: both proceed independently in the same cycle.
- `outN_ready` asserted while `outN_valid`=0 has no effect; counters do not change.

## Timing
- Reset values (`rst_n` low, asynchronous): all FIFO entries = 0x00, pointers = 0, `count0`=`count1`=0, `out0_valid`=`out1_valid`=0, `out0_data`=`out1_data`=0x00, `xfer0`=`xfer1`=0.
- `in_ready` after reset = 1 for either `in_sel`.
- Reset mid-operation: all buffered bytes are discarded and counters are cleared immediately on assertion, with no clock required.
- Reset release: operation resumes on the first rising edge with `rst_n` high.
- Latency: a byte accepted at edge N appears on `outN_data` with `outN_valid`=1 after edge N, when its FIFO was empty. Minimum input-to-output latency is 1 cycle; there is no combinational input-to-output path.
- Throughput: one byte per cycle into a port whose consumer holds `ready`=1 continuously.
- Occupancy and `xferN` reflect all handshakes completed at the most recent edge.

## Test plan
- Reset, then send 0xA5 with sel=0, holding `out0_ready`=0 → after 1 edge: `out0_valid`=1, `out0_data`=0xA5, `count0`=1, `out1_valid`=0. Set `out0_ready`=1 → after the next edge: `count0`=0, `xfer0`=1.
- Fill port 1 with 0x11 and 0x22 while `out1_ready`=0 → `count1`=2. Present 0x33 with sel=1 → `in_ready`=0. Switch `in_sel` to 0 → `in_ready`=1. Release `out1_ready` → port 1 emits 0x11 then 0x22 in order.
- Streaming: 16 bytes 0x00..0x0F with alternating sel, both readies held 1 → `in_ready` stays 1. Port 0 receives the even bytes in order, port 1 the odd bytes. Final `xfer0`=`xfer1`=8.
- Simultaneous push and pop at `count0`=1 (head 0x40, push 0x41, `out0_ready`=1) → after the edge: `count0`=1, `out0_data`=0x41, `xfer0` incremented by 1.
- Wrap: 257 bytes to port 0 with `out0_ready`=1 → `xfer0`=0x01, and the data sequence is intact across pointer wraps.
- Assert `rst_n`=0 between clock edges with `count0`=2 and `count1`=1 → all outputs return to their reset values immediately. After release, the first byte sent appears after 1 edge.
